// File: rtl/int_ctrl_vec.sv
// Interrupt/exception controller for the single-cycle RISC-V core.
// Chooses PC redirects for traps and mret, and holds mepc, mcause and the one-level trap state.
module int_ctrl_vec #(
   parameter int N_INT       = 4,
   parameter int XLEN        = 32,
   parameter bit VECTORED    = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_INT-1:0] int_src,
   input  logic             ecall,
   input  logic             ill_instr,
   input  logic             mret,
   input  logic [XLEN-1:0]  pc_cur,
   input  logic [XLEN-1:0]  pc_next,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [XLEN-1:0]  cfg_wdata,
   output logic [XLEN-1:0]  cfg_rdata,
   output logic             redirect,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [XLEN-1:0]  mepc,
   output logic [XLEN-1:0]  mcause,
   output logic             in_trap
);
   typedef enum logic {ST_RUN, ST_TRAP} state_e;

   localparam logic [XLEN-1:0] CAUSE_ILL   = XLEN'(2);
   localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);

   logic [N_INT-1:0] sync_q [SYNC_STAGES];
   logic [N_INT-1:0] sync_d [SYNC_STAGES];
   logic [N_INT-1:0] s_dly_q, s_dly_d;
   logic [N_INT-1:0] enable_q, enable_d;
   logic [N_INT-1:0] mode_q, mode_d;
   logic [N_INT-1:0] pend_q, pend_d;
   logic [XLEN-1:0]  mtvec_q, mtvec_d;
   logic [XLEN-1:0]  mepc_q, mepc_d;
   logic [XLEN-1:0]  mcause_q, mcause_d;
   state_e           state_q, state_d;

   logic [N_INT-1:0] sync_s;
   logic [N_INT-1:0] pending;
   logic [N_INT-1:0] act;
   logic [N_INT-1:0] take_mask;
   logic [N_INT-1:0] w1c_mask;
   logic [4:0]       irq_code;
   logic             take_ill;
   logic             take_ecall;
   logic             take_ret;
   logic             take_irq;
   logic [XLEN-1:0]  irq_target;
   logic             unused_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_d[gi] = int_src;
         end else begin : g_rest
            assign sync_d[gi] = sync_q[gi-1];
         end
      end
   endgenerate

   assign unused_wdata = ^cfg_wdata[XLEN-1:N_INT];

   // Trap decision: combinational on registered state, fixed priority.
   always_comb begin
      sync_s    = sync_q[SYNC_STAGES-1];
      pending   = (mode_q & pend_q) | (~mode_q & sync_s);
      act       = pending & enable_q;
      take_mask = act & (~act + N_INT'(1));
      irq_code  = 5'd0;
      for (int i = N_INT - 1; i >= 0; i--) begin
         if (act[i]) begin
            irq_code = 5'(16 + i);
         end
      end

      take_ill   = ill_instr | (mret & (state_q == ST_RUN));
      take_ecall = ecall & ~take_ill;
      take_ret   = mret & (state_q == ST_TRAP) & ~ill_instr & ~ecall;
      take_irq   = (state_q == ST_RUN) & (|act) & ~ill_instr & ~ecall & ~mret;

      irq_target = VECTORED ? (mtvec_q + XLEN'({irq_code, 2'b00})) : mtvec_q;

      redirect    = take_ill | take_ecall | take_ret | take_irq;
      redirect_pc = '0;
      if (take_ill || take_ecall) begin
         redirect_pc = mtvec_q;
      end else if (take_ret) begin
         redirect_pc = mepc_q;
      end else if (take_irq) begin
         redirect_pc = irq_target;
      end
   end

   always_comb begin
      state_d  = state_q;
      mepc_d   = mepc_q;
      mcause_d = mcause_q;
      if (take_ill || take_ecall) begin
         mepc_d   = pc_cur;
         mcause_d = take_ill ? CAUSE_ILL : CAUSE_ECALL;
         state_d  = ST_TRAP;
      end else if (take_ret) begin
         state_d = ST_RUN;
      end else if (take_irq) begin
         // The interrupted instruction still retires, so the return point is pc_next.
         mepc_d             = pc_next;
         mcause_d           = '0;
         mcause_d[XLEN-1]   = 1'b1;
         mcause_d[4:0]      = irq_code;
         state_d            = ST_TRAP;
      end
   end

   always_comb begin
      enable_d = enable_q;
      mode_d   = mode_q;
      mtvec_d  = mtvec_q;
      w1c_mask = '0;
      if (cfg_we) begin
         case (cfg_addr)
            2'd0:    enable_d = cfg_wdata[N_INT-1:0];
            2'd1:    mode_d   = cfg_wdata[N_INT-1:0];
            2'd2:    w1c_mask = cfg_wdata[N_INT-1:0];
            default: mtvec_d  = {cfg_wdata[XLEN-1:2], 2'b00};
         endcase
      end
      // A new edge in the same cycle as a clear leaves the bit set.
      pend_d  = (pend_q & ~(w1c_mask | (take_irq ? take_mask : '0))) | (sync_s & ~s_dly_q);
      s_dly_d = sync_s;
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         2'd0:    cfg_rdata[N_INT-1:0] = enable_q;
         2'd1:    cfg_rdata[N_INT-1:0] = mode_q;
         2'd2:    cfg_rdata[N_INT-1:0] = pending;
         default: cfg_rdata            = mtvec_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         s_dly_q  <= '0;
         enable_q <= '0;
         mode_q   <= '0;
         pend_q   <= '0;
         mtvec_q  <= '0;
         mepc_q   <= '0;
         mcause_q <= '0;
         state_q  <= ST_RUN;
      end else begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_d[k];
         end
         s_dly_q  <= s_dly_d;
         enable_q <= enable_d;
         mode_q   <= mode_d;
         pend_q   <= pend_d;
         mtvec_q  <= mtvec_d;
         mepc_q   <= mepc_d;
         mcause_q <= mcause_d;
         state_q  <= state_d;
      end
   end

   assign mepc    = mepc_q;
   assign mcause  = mcause_q;
   assign in_trap = (state_q == ST_TRAP);

endmodule

// File: doc/int_ctrl_vec.md
Name: int_ctrl_vec

Overview:
- Parametrised interrupt/exception controller for the single-cycle RISC-V core; next generation of the single-INT0 trap path.
- Takes N_INT external interrupt lines (per-channel edge/level mode and enable), plus ecall, illegal-instruction and mret from the decoder.
- Produces a PC redirect: a vectored or direct trap target, or the mret return target. Holds mepc/mcause and a one-level trap state.
- Sits between the control unit and the datapath PC-select mux.

Parameters:
- N_INT, 4, number of external interrupt channels (1..16).
- XLEN, 32, width of PC, CSR and config data.
- VECTORED, 1: 1 = interrupt target is mtvec + 4*cause_code; 0 = all traps go to mtvec.
- SYNC_STAGES, 2, synchroniser depth on each int_src line (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- int_src  in  N_INT  raw interrupt requests, asynchronous to clk.
- ecall  in  1  current instruction is ecall.
- ill_instr  in  1  current instruction is illegal.
- mret  in  1  current instruction is mret.
- pc_cur  in  XLEN  PC of the current instruction.
- pc_next  in  XLEN  sequential/branch next PC computed by the datapath.
- cfg_we  in  1  config register write strobe.
- cfg_addr  in  2  register select: 0 ENABLE, 1 MODE (1=edge), 2 PENDING (W1C), 3 MTVEC.
- cfg_wdata  in  XLEN  config write data.
- cfg_rdata  out  XLEN  config read data (combinational from cfg_addr).
- redirect  out  1  datapath must load redirect_pc instead of pc_next this cycle.
- redirect_pc  out  XLEN  trap target or mepc.
- mepc  out  XLEN  saved return PC.
- mcause  out  XLEN  saved cause.
- in_trap  out  1  controller is in TRAP state (interrupts masked).

Behaviour:
- Reset (rst=0, async): ENABLE=0, MODE=0, PENDING=0, MTVEC=0, mepc=0, mcause=0, synchronisers=0, state=RUN. Outputs: redirect=0, in_trap=0, redirect_pc=0.
- Synchroniser: int_src[i] passes through SYNC_STAGES flops giving s[i]; s_d[i] is s[i] delayed one cycle.
- PENDING[i] in edge mode:
  - set on s[i] & ~s_d[i];
  - cleared by a W1C write with bit=1, or when the interrupt is accepted;
  - a set event in the same cycle as a clear wins (bit stays 1).
- PENDING[i] in level mode: equals s[i]; W1C writes have no effect.
- Latency: a raw edge held stable is visible in PENDING SYNC_STAGES+1 cycles later. It can be taken in that same cycle.
- Active set: act = PENDING & ENABLE. The winner is the lowest index set in act (fixed priority, channel 0 highest).
- States: RUN and TRAP. The decision is combinational on registered state; all updates occur on the clk edge.
- Priority, highest first:
  1. ill_instr, or mret while in RUN: illegal exception.
  2. ecall.
  3. mret while in TRAP.
  4. interrupt while in RUN with act != 0.
- Exception (any state): redirect=1, redirect_pc=MTVEC. On the edge: mepc<=pc_cur; mcause<=2 for illegal or 11 for ecall; state<=TRAP.
- mret in TRAP: redirect=1, redirect_pc=mepc. On the edge: state<=RUN.
- Interrupt i: redirect=1.
  - redirect_pc = VECTORED ? MTVEC+4*(16+i) : MTVEC.
  - On the edge: mepc<=pc_next (the current instruction completes); mcause<={1'b1, (16+i) zero-extended to XLEN-1}; edge-mode PENDING[i] cleared; state<=TRAP.
- No redirect otherwise. Interrupts are never taken in TRAP (no nesting); they stay pending.
- mret with act!=0 in the same cycle: mret is taken; the interrupt is taken next cycle (mepc = return target's successor path via pc_next).
- A config write takes effect on the edge. The trap decision in the write cycle uses the old ENABLE/MODE/MTVEC.
- MTVEC[1:0] is forced to 0 on write.
- Reset asserted mid-trap returns to RUN and clears all state immediately.
- cfg_rdata: addresses 0/1/2 return the register zero-extended; address 3 returns MTVEC.

Test Plan:
- Reset, then ENABLE=0x1, MODE=0x1, MTVEC=0x100. Rising edge on int_src[0] with pc_next=0x40 -> after 3 cycles redirect=1, redirect_pc=0x140, then mepc=0x40, mcause=0x80000010, in_trap=1, PENDING[0]=0.
- Channels 1 and 3 pending and enabled together -> channel 1 taken, redirect_pc=0x144. After mret (redirect_pc=mepc, in_trap=0), channel 3 is taken next cycle with redirect_pc=0x14C.
- ecall at pc_cur=0x20 while int channel 0 pending -> exception wins: redirect_pc=0x100, mcause=11, mepc=0x20. Channel 0 stays pending.
- mret in RUN -> illegal trap, mcause=2, mepc=pc_cur. ill_instr while in TRAP -> mepc overwritten, stays TRAP.
- Level-mode channel 2 held high -> taken; after mret it is re-taken. Writing PENDING=0x4 has no effect. Edge clear and new edge in the same cycle -> bit stays 1.
- VECTORED=0 build: any interrupt gives redirect_pc=MTVEC. Assert rst low while in TRAP -> in_trap=0, mepc=0, PENDING=0 asynchronously.
